// File: rtl/wf68k30l_exc_arbiter.sv
// Exception/interrupt arbiter: latches internal requests and a filtered IPL, picks one by fixed
// priority, runs the IACK vector fetch and presents vector plus VBR-relative address to the sequencer.
module wf68k30l_exc_arbiter #(
  parameter int NUM_SRC = 8,
  parameter int ADDR_W  = 32
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [NUM_SRC-1:0]   i_exc_req,
  input  logic [8*NUM_SRC-1:0] i_exc_vec_tab,
  input  logic [2:0]           i_irq_level,
  input  logic [2:0]           i_sr_ipl,
  input  logic [ADDR_W-1:0]    i_vbr,
  input  logic                 i_take_rdy,
  output logic                 o_iack_req,
  output logic [2:0]           o_iack_lvl,
  input  logic                 i_iack_vec_valid,
  input  logic [7:0]           i_iack_vec,
  input  logic                 i_iack_autovec,
  input  logic                 i_iack_spurious,
  output logic                 o_exc_valid,
  output logic [7:0]           o_exc_vector,
  output logic [ADDR_W-1:0]    o_exc_addr,
  output logic                 o_exc_is_irq,
  output logic [2:0]           o_exc_irq_lvl,
  input  logic                 i_exc_ack,
  output logic [NUM_SRC-1:0]   o_pend
);

  localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic [1:0] {S_IDLE, S_IACK, S_PRESENT} state_t;

  state_t              r_state, w_state_nxt;
  logic [NUM_SRC-1:0]  r_pend, w_clr;
  logic [2:0]          r_ipl_s, r_ipl_q, w_ipl_q_nxt;
  logic                r_nmi, w_nmi_clr;
  logic                r_iack_req, w_iack_req_nxt;
  logic [2:0]          r_iack_lvl, w_iack_lvl_nxt;
  logic                r_exc_valid, w_valid_nxt;
  logic [7:0]          r_exc_vector, w_vec_nxt;
  logic [ADDR_W-1:0]   r_exc_addr, w_addr_nxt;
  logic                r_exc_is_irq, w_is_irq_nxt;
  logic [2:0]          r_exc_irq_lvl, w_irq_lvl_nxt;
  logic [SW-1:0]       r_src, w_src_nxt, w_sel_idx;
  logic [7:0]          w_sel_vec;
  logic                w_any_pend, w_irq_elig, w_iack_term;

  // Scan downwards so the lowest-index pending source wins.
  always_comb begin
    w_sel_idx = '0;
    w_sel_vec = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (r_pend[i]) begin
        w_sel_idx = SW'(i);
        w_sel_vec = i_exc_vec_tab[8*i +: 8];
      end
    end
  end

  assign w_any_pend  = |r_pend;
  assign w_irq_elig  = (r_ipl_q > i_sr_ipl) || r_nmi;
  assign w_iack_term = i_iack_spurious || i_iack_autovec || i_iack_vec_valid;
  assign w_ipl_q_nxt = (i_irq_level == r_ipl_s) ? i_irq_level : r_ipl_q;

  always_comb begin
    w_state_nxt    = r_state;
    w_iack_req_nxt = r_iack_req;
    w_iack_lvl_nxt = r_iack_lvl;
    w_valid_nxt    = r_exc_valid;
    w_vec_nxt      = r_exc_vector;
    w_is_irq_nxt   = r_exc_is_irq;
    w_irq_lvl_nxt  = r_exc_irq_lvl;
    w_src_nxt      = r_src;
    w_clr          = '0;
    w_nmi_clr      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_take_rdy && w_any_pend) begin
          w_vec_nxt     = w_sel_vec;
          w_is_irq_nxt  = 1'b0;
          w_irq_lvl_nxt = 3'd0;
          w_src_nxt     = w_sel_idx;
          w_valid_nxt   = 1'b1;
          w_state_nxt   = S_PRESENT;
        end else if (i_take_rdy && w_irq_elig) begin
          w_iack_req_nxt = 1'b1;
          w_iack_lvl_nxt = r_nmi ? 3'd7 : r_ipl_q;
          w_state_nxt    = S_IACK;
        end
      end
      S_IACK: begin
        if (w_iack_term) begin
          if (i_iack_spurious)     w_vec_nxt = 8'h18;
          else if (i_iack_autovec) w_vec_nxt = 8'h18 + {5'd0, r_iack_lvl};
          else                     w_vec_nxt = i_iack_vec;
          w_is_irq_nxt   = 1'b1;
          w_irq_lvl_nxt  = r_iack_lvl;
          w_iack_req_nxt = 1'b0;
          w_valid_nxt    = 1'b1;
          w_state_nxt    = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (i_exc_ack) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = S_IDLE;
          if (r_exc_is_irq) begin
            w_nmi_clr = (r_exc_irq_lvl == 3'd7);
          end else begin
            for (int i = 0; i < NUM_SRC; i++) w_clr[i] = (r_src == SW'(i));
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Address is only captured on a load, so a later VBR change leaves it untouched.
  assign w_addr_nxt = i_vbr + ADDR_W'({w_vec_nxt, 2'b00});

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_pend        <= '0;
      r_ipl_s       <= '0;
      r_ipl_q       <= '0;
      r_nmi         <= 1'b0;
      r_iack_req    <= 1'b0;
      r_iack_lvl    <= '0;
      r_exc_valid   <= 1'b0;
      r_exc_vector  <= '0;
      r_exc_addr    <= '0;
      r_exc_is_irq  <= 1'b0;
      r_exc_irq_lvl <= '0;
      r_src         <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_pend        <= (r_pend & ~w_clr) | i_exc_req;
      r_ipl_s       <= i_irq_level;
      r_ipl_q       <= w_ipl_q_nxt;
      r_nmi         <= ((w_ipl_q_nxt == 3'd7) && (r_ipl_q != 3'd7)) || (r_nmi && !w_nmi_clr);
      r_iack_req    <= w_iack_req_nxt;
      r_iack_lvl    <= w_iack_lvl_nxt;
      r_exc_valid   <= w_valid_nxt;
      r_exc_vector  <= w_vec_nxt;
      r_exc_is_irq  <= w_is_irq_nxt;
      r_exc_irq_lvl <= w_irq_lvl_nxt;
      r_src         <= w_src_nxt;
      if (w_valid_nxt && !r_exc_valid) r_exc_addr <= w_addr_nxt;
    end
  end

  assign o_iack_req    = r_iack_req;
  assign o_iack_lvl    = r_iack_lvl;
  assign o_exc_valid   = r_exc_valid;
  assign o_exc_vector  = r_exc_vector;
  assign o_exc_addr    = r_exc_addr;
  assign o_exc_is_irq  = r_exc_is_irq;
  assign o_exc_irq_lvl = r_exc_irq_lvl;
  assign o_pend        = r_pend;

endmodule

// File: tb/tb_wf68k30l_exc_arbiter.sv
// Directed bench for wf68k30l_exc_arbiter: linear steps, hand-computed expectations,
// immediate assertions at every check point.
module tb_wf68k30l_exc_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  exc_req;
  logic [63:0] vec_tab;
  logic [2:0]  irq_level, sr_ipl;
  logic [31:0] vbr;
  logic        take_rdy;
  logic        iack_req;
  logic [2:0]  iack_lvl;
  logic        iack_vec_valid, iack_autovec, iack_spurious;
  logic [7:0]  iack_vec;
  logic        exc_valid;
  logic [7:0]  exc_vector;
  logic [31:0] exc_addr;
  logic        exc_is_irq;
  logic [2:0]  exc_irq_lvl;
  logic        exc_ack;
  logic [7:0]  pend;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wf68k30l_exc_arbiter #(.NUM_SRC(8), .ADDR_W(32)) dut (
    .i_clk(clk), .i_reset(reset), .i_exc_req(exc_req), .i_exc_vec_tab(vec_tab),
    .i_irq_level(irq_level), .i_sr_ipl(sr_ipl), .i_vbr(vbr), .i_take_rdy(take_rdy),
    .o_iack_req(iack_req), .o_iack_lvl(iack_lvl), .i_iack_vec_valid(iack_vec_valid),
    .i_iack_vec(iack_vec), .i_iack_autovec(iack_autovec), .i_iack_spurious(iack_spurious),
    .o_exc_valid(exc_valid), .o_exc_vector(exc_vector), .o_exc_addr(exc_addr),
    .o_exc_is_irq(exc_is_irq), .o_exc_irq_lvl(exc_irq_lvl), .i_exc_ack(exc_ack), .o_pend(pend)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; exc_req = '0; irq_level = '0; sr_ipl = '0; vbr = 32'h1000; take_rdy = 1'b1;
    iack_vec_valid = 1'b0; iack_autovec = 1'b0; iack_spurious = 1'b0; iack_vec = '0; exc_ack = 1'b0;
    for (int i = 0; i < 8; i++) vec_tab[8*i +: 8] = 8'h40 + 8'(i);
    vec_tab[31:24] = 8'h05;
    step(2);
    chk("rst_valid", exc_valid, 0);
    chk("rst_iack", iack_req, 0);
    chk("rst_pend", pend, 0);
    chk("rst_vec", exc_vector, 0);
    chk("rst_addr", exc_addr, 0);
    reset = 1'b0;

    // T1: single request, latency and address, set-wins on retire
    exc_req = 8'h08; step(1); exc_req = '0;
    chk("t1_pend", pend, 8'h08);
    chk("t1_valid_early", exc_valid, 0);
    step(1);
    chk("t1_valid", exc_valid, 1);
    chk("t1_vec", exc_vector, 8'h05);
    chk("t1_addr", exc_addr, 32'h1014);
    chk("t1_isirq", exc_is_irq, 0);
    step(1);
    chk("t1_hold", exc_valid, 1);
    exc_ack = 1'b1; exc_req = 8'h08; step(1); exc_ack = 1'b0; exc_req = '0;
    chk("t1_ack_valid", exc_valid, 0);
    chk("t1_setwins", pend, 8'h08);
    step(1);
    chk("t1_repres", exc_valid, 1);
    exc_ack = 1'b1; step(1); exc_ack = 1'b0;
    chk("t1_retire", pend, 8'h00);
    chk("t1_retire_valid", exc_valid, 0);

    // Ack without a presented exception is ignored
    take_rdy = 1'b0; exc_req = 8'h04; step(1); exc_req = '0;
    exc_ack = 1'b1; step(1); exc_ack = 1'b0;
    chk("ign_ack_pend", pend, 8'h04);
    chk("ign_ack_valid", exc_valid, 0);
    take_rdy = 1'b1; step(1);
    chk("ign_vec", exc_vector, 8'h42);
    exc_ack = 1'b1; step(1); exc_ack = 1'b0;
    chk("ign_retire", pend, 8'h00);

    // T2: two sources at once, lowest index first, one idle cycle between
    exc_req = 8'h22; step(1); exc_req = '0;
    chk("t2_pend", pend, 8'h22);
    step(1);
    chk("t2_vec1", exc_vector, 8'h41);
    chk("t2_addr1", exc_addr, 32'h1104);
    exc_ack = 1'b1; step(1); exc_ack = 1'b0;
    chk("t2_gap", exc_valid, 0);
    chk("t2_pend5", pend, 8'h20);
    step(1);
    chk("t2_valid5", exc_valid, 1);
    chk("t2_vec5", exc_vector, 8'h45);
    chk("t2_addr5", exc_addr, 32'h1114);
    exc_ack = 1'b1; step(1); exc_ack = 1'b0;
    chk("t2_pend0", pend, 8'h00);

    // T3: level 3 over mask 2, autovector
    sr_ipl = 3'd2; irq_level = 3'd3; step(2);
    chk("t3_iack_early", iack_req, 0);
    step(1);
    chk("t3_iack", iack_req, 1);
    chk("t3_lvl", iack_lvl, 3);
    step(1);
    chk("t3_iack_hold", iack_req, 1);
    iack_autovec = 1'b1; step(1); iack_autovec = 1'b0;
    chk("t3_valid", exc_valid, 1);
    chk("t3_vec", exc_vector, 8'h1B);
    chk("t3_irqlvl", exc_irq_lvl, 3);
    chk("t3_isirq", exc_is_irq, 1);
    chk("t3_iack_drop", iack_req, 0);
    chk("t3_addr", exc_addr, 32'h106C);
    sr_ipl = 3'd3; exc_ack = 1'b1; step(1); exc_ack = 1'b0;
    chk("t3_ack", exc_valid, 0);
    iack_spurious = 1'b1; step(1); iack_spurious = 1'b0;
    step(2);
    chk("t3_masked", iack_req, 0);
    chk("t3_stray_term", exc_valid, 0);
    irq_level = 3'd0; step(2); sr_ipl = 3'd0;

    // Internal request beats an eligible IRQ; autovector beats vector-valid
    irq_level = 3'd4; exc_req = 8'h40; step(1); exc_req = '0;
    step(1);
    chk("pri_valid", exc_valid, 1);
    chk("pri_isirq", exc_is_irq, 0);
    chk("pri_vec", exc_vector, 8'h46);
    chk("pri_noiack", iack_req, 0);
    exc_ack = 1'b1; step(1); exc_ack = 1'b0;
    step(1);
    chk("pri_iack", iack_req, 1);
    chk("pri_lvl", iack_lvl, 4);
    iack_vec = 8'h64; iack_vec_valid = 1'b1; iack_autovec = 1'b1; step(1);
    iack_vec_valid = 1'b0; iack_autovec = 1'b0;
    chk("pri_autovec", exc_vector, 8'h1C);
    chk("pri_irqlvl", exc_irq_lvl, 4);
    sr_ipl = 3'd4; exc_ack = 1'b1; step(1); exc_ack = 1'b0;
    irq_level = 3'd0; step(2);

    // T4: NMI edge with mask 7, uninitialised vector passes through
    sr_ipl = 3'd7; irq_level = 3'd7; step(2);
    chk("t4_iack_early", iack_req, 0);
    step(1);
    chk("t4_iack", iack_req, 1);
    chk("t4_lvl", iack_lvl, 7);
    iack_vec = 8'h0F; iack_vec_valid = 1'b1; step(1); iack_vec_valid = 1'b0;
    chk("t4_vec", exc_vector, 8'h0F);
    chk("t4_irqlvl", exc_irq_lvl, 7);
    chk("t4_addr", exc_addr, 32'h103C);
    exc_ack = 1'b1; step(1); exc_ack = 1'b0;
    chk("t4_ack", exc_valid, 0);
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("t4_no_second", iack_req, 0);
    end
    irq_level = 3'd0; step(2); sr_ipl = 3'd0;

    // T5: spurious wins, commitment while level drops, glitch rejection, address wrap
    irq_level = 3'd2; step(3);
    chk("t5_iack", iack_req, 1);
    chk("t5_lvl", iack_lvl, 2);
    irq_level = 3'd0; step(3);
    chk("t5_committed", iack_req, 1);
    iack_spurious = 1'b1; iack_autovec = 1'b1; step(1);
    iack_spurious = 1'b0; iack_autovec = 1'b0;
    chk("t5_spur_vec", exc_vector, 8'h18);
    chk("t5_spur_lvl", exc_irq_lvl, 2);
    chk("t5_spur_isirq", exc_is_irq, 1);
    exc_ack = 1'b1; step(1); exc_ack = 1'b0;
    step(2);
    chk("t5_idle", iack_req, 0);
    irq_level = 3'd5; step(1); irq_level = 3'd0;
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("t5_glitch", iack_req, 0);
    end
    vbr = 32'hFFFF_FFF0; vec_tab[63:56] = 8'h08;
    exc_req = 8'h80; step(1); exc_req = '0;
    step(1);
    chk("t5_wrap_vec", exc_vector, 8'h08);
    chk("t5_wrap_addr", exc_addr, 32'h0000_0010);
    vbr = 32'h2000; step(1);
    chk("t5_addr_stable", exc_addr, 32'h0000_0010);
    chk("t5_valid_stable", exc_valid, 1);
    exc_ack = 1'b1; step(1); exc_ack = 1'b0;

    // T6: reset during IACK and during PRESENT
    irq_level = 3'd6; step(3);
    chk("t6_iack", iack_req, 1);
    exc_req = 8'h01; step(1); exc_req = '0;
    chk("t6_pend_in_iack", pend, 8'h01);
    chk("t6_iack_hold", iack_req, 1);
    reset = 1'b1; step(1); reset = 1'b0;
    chk("t6_rst_iack", iack_req, 0);
    chk("t6_rst_lvl", iack_lvl, 0);
    chk("t6_rst_pend", pend, 0);
    chk("t6_rst_valid", exc_valid, 0);
    step(2);
    chk("t6_refilter", iack_req, 0);
    step(1);
    chk("t6_resume_iack", iack_req, 1);
    chk("t6_resume_lvl", iack_lvl, 6);
    iack_vec = 8'h70; iack_vec_valid = 1'b1; step(1); iack_vec_valid = 1'b0;
    chk("t6_vec", exc_vector, 8'h70);
    chk("t6_addr", exc_addr, 32'h21C0);
    reset = 1'b1; step(1); reset = 1'b0; irq_level = 3'd0;
    chk("t6_rst2_valid", exc_valid, 0);
    chk("t6_rst2_vec", exc_vector, 0);
    chk("t6_rst2_addr", exc_addr, 0);
    chk("t6_rst2_isirq", exc_is_irq, 0);
    chk("t6_rst2_irqlvl", exc_irq_lvl, 0);
    exc_req = 8'h04; step(1); exc_req = '0;
    step(1);
    chk("t6_after_valid", exc_valid, 1);
    chk("t6_after_vec", exc_vector, 8'h42);
    chk("t6_after_addr", exc_addr, 32'h2108);
    exc_ack = 1'b1; step(1); exc_ack = 1'b0;
    chk("t6_after_pend", pend, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
